// File: rtl/input_event_port_if.sv
// CPU-side dmem-style read bus for the button event port.
// The master drives the strobe and address. The slave returns registered data with a one-cycle valid pulse.
interface input_event_port_if;
    logic        rd_en;
    logic [11:0] addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (output rd_en, output addr, input rd_data, input rd_valid);
    modport slave  (input rd_en, input addr, output rd_data, output rd_valid);
endinterface

// File: rtl/input_event_port.sv
// Memory-mapped button port: synchronises and debounces the active-low buttons.
// Press events are latched as sticky flags plus a saturating fire counter, cleared when the CPU reads them.
module input_event_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 5000000,
    parameter int unsigned CNT_W           = 23,
    parameter logic [11:0] BASE_ADDR       = 12'hFF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_left_n,
    input  logic                btn_right_n,
    input  logic                btn_fire_n,
    input_event_port_if.slave   bus,
    output logic [2:0]          level,
    output logic                irq
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       sync_meta;
    logic [2:0]       sync_out;
    logic [2:0]       pressed;
    logic [2:0]       debounced;
    logic [2:0]       rise;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       sticky;
    logic [7:0]       fire_count;
    logic             hit;
    logic [1:0]       offset;
    logic             clr_events;
    logic             clr_count;
    logic [31:0]      read_mux;

    // The synchroniser keeps the raw active-low polarity, so its reset value of 1 means released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 3'b111;
            sync_out  <= 3'b111;
        end else begin
            sync_meta <= {btn_fire_n, btn_right_n, btn_left_n};
            sync_out  <= sync_meta;
        end
    end

    assign pressed = ~sync_out;

    always_comb begin
        rise = '0;
        for (int i = 0; i < 3; i++) begin
            rise[i] = pressed[i] && !debounced[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debounced <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pressed[i] == debounced[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    debounced[i] <= ~debounced[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign hit        = (bus.addr[11:2] == BASE_ADDR[11:2]);
    assign offset     = bus.addr[1:0];
    assign clr_events = bus.rd_en && hit && (offset == 2'd1);
    assign clr_count  = bus.rd_en && hit && (offset == 2'd2);

    always_comb begin
        read_mux = '0;
        if (hit) begin
            case (offset)
                2'd0:    read_mux = {21'd0, sticky, 5'd0, debounced};
                2'd1:    read_mux = {29'd0, sticky};
                2'd2:    read_mux = {24'd0, fire_count};
                default: read_mux = '0;
            endcase
        end
    end

    // A new press in the same cycle as a clearing read survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky     <= '0;
            fire_count <= '0;
        end else begin
            sticky <= (clr_events ? 3'b000 : sticky) | rise;
            if (clr_count) begin
                fire_count <= {7'd0, rise[2]};
            end else if (rise[2] && (fire_count != 8'hFF)) begin
                fire_count <= fire_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= read_mux;
            end
        end
    end

    assign level = debounced;
    assign irq   = |sticky;
endmodule

// File: tb/tb_input_event_port.sv
// Directed, table-driven bench for input_event_port with a short debounce window.
// Expected values are hand-derived from the register map and the debounce timing.
module tb_input_event_port;
    localparam int D = 4;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        irq_after;
    } read_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn_n;
    logic [2:0] level;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    input_event_port_if bus();

    input_event_port #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(23),
        .BASE_ADDR(12'hFF0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_left_n(btn_n[0]),
        .btn_right_n(btn_n[1]),
        .btn_fire_n(btn_n[2]),
        .bus(bus),
        .level(level),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [11:0] a, output logic [31:0] data, output logic valid);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick(1);
        bus.rd_en = 1'b0;
        data  = bus.rd_data;
        valid = bus.rd_valid;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] expected);
        logic [31:0] d;
        logic        v;
        apply_stimulus(a, d, v);
        check_output({name, " rd_valid"}, {31'd0, v}, 32'd1);
        check_output(name, d, expected);
    endtask

    task automatic press_fire();
        btn_n[2] = 1'b0;
        tick(D + 3);
        btn_n[2] = 1'b1;
        tick(D + 3);
    endtask

    initial begin
        read_vec_t   vecs [10];
        logic [31:0] d;
        logic        v;
        int          model_count;

        vecs[0] = '{12'hFF3, 32'h0,   1'b1};
        vecs[1] = '{12'h000, 32'h0,   1'b1};
        vecs[2] = '{12'hFF0, 32'h404, 1'b1};
        vecs[3] = '{12'hFF1, 32'h4,   1'b0};
        vecs[4] = '{12'hFF1, 32'h0,   1'b0};
        vecs[5] = '{12'hFF0, 32'h4,   1'b0};
        vecs[6] = '{12'hFF2, 32'h1,   1'b0};
        vecs[7] = '{12'hFF2, 32'h0,   1'b0};
        vecs[8] = '{12'hFF4, 32'h0,   1'b0};
        vecs[9] = '{12'h3F1, 32'h0,   1'b0};

        reset     = 1'b0;
        btn_n     = 3'b111;
        bus.rd_en = 1'b0;
        bus.addr  = 12'h000;
        tick(3);
        check_output("reset level", {29'd0, level}, 32'd0);
        check_output("reset irq", {31'd0, irq}, 32'd0);
        check_output("reset rd_data", bus.rd_data, 32'd0);
        check_output("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        reset = 1'b1;
        tick(1);
        check_output("idle level", {29'd0, level}, 32'd0);
        check_output("idle rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        read_check("idle status", 12'hFF0, 32'h0);
        tick(1);
        check_output("rd_valid pulse", {31'd0, bus.rd_valid}, 32'd0);

        // Clean fire press: level must rise on exactly the sixth edge.
        btn_n[2] = 1'b0;
        tick(D + 1);
        check_output("fire level early", {29'd0, level}, 32'd0);
        check_output("fire irq early", {31'd0, irq}, 32'd0);
        tick(1);
        check_output("fire level", {29'd0, level}, 32'h4);
        check_output("fire irq", {31'd0, irq}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
            check_output($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].irq_after});
        end
        check_output("level after table", {29'd0, level}, 32'h4);

        btn_n[2] = 1'b1;
        tick(D + 4);
        check_output("fire release level", {29'd0, level}, 32'd0);
        check_output("release no irq", {31'd0, irq}, 32'd0);
        read_check("release no event", 12'hFF1, 32'h0);

        // Glitch rejection on left, then a real press.
        btn_n[0] = 1'b0;
        tick(3);
        btn_n[0] = 1'b1;
        tick(10);
        check_output("glitch level", {29'd0, level}, 32'd0);
        check_output("glitch irq", {31'd0, irq}, 32'd0);
        read_check("glitch events", 12'hFF1, 32'h0);
        btn_n[0] = 1'b0;
        tick(10);
        check_output("left level", {29'd0, level}, 32'h1);
        check_output("left irq", {31'd0, irq}, 32'd1);
        read_check("left status", 12'hFF0, 32'h101);
        btn_n[0] = 1'b1;
        tick(D + 4);
        read_check("left events", 12'hFF1, 32'h1);
        check_output("left irq cleared", {31'd0, irq}, 32'd0);

        // EVENTS read landing on the same edge that level[1] rises.
        btn_n[1] = 1'b0;
        tick(D + 1);
        apply_stimulus(12'hFF1, d, v);
        check_output("race ev rd_valid", {31'd0, v}, 32'd1);
        check_output("race ev data", d, 32'h0);
        check_output("race ev level", {29'd0, level}, 32'h2);
        check_output("race ev irq", {31'd0, irq}, 32'd1);
        read_check("race ev reread", 12'hFF1, 32'h2);
        btn_n[1] = 1'b1;
        tick(D + 4);

        for (int i = 0; i < 5; i++) begin
            press_fire();
        end
        btn_n[2] = 1'b0;
        tick(D + 1);
        apply_stimulus(12'hFF2, d, v);
        check_output("race cnt data", d, 32'd5);
        check_output("race cnt level", {29'd0, level}, 32'h4);
        read_check("race cnt reread", 12'hFF2, 32'd1);
        btn_n[2] = 1'b1;
        tick(D + 4);
        read_check("race cnt events", 12'hFF1, 32'h4);

        // Saturation of the fire counter.
        model_count = 0;
        for (int i = 0; i < 300; i++) begin
            press_fire();
            model_count = (model_count == 255) ? 255 : model_count + 1;
        end
        read_check("saturated count", 12'hFF2, 32'(model_count));
        read_check("count cleared", 12'hFF2, 32'd0);

        // Async reset in the middle of a debounce and a pending read.
        btn_n[1] = 1'b0;
        tick(D + 3);
        btn_n[1] = 1'b1;
        tick(D + 3);
        press_fire();
        read_check("pre-reset status", 12'hFF0, 32'h600);
        btn_n[0] = 1'b0;
        tick(4);
        bus.rd_en = 1'b1;
        bus.addr  = 12'hFF0;
        #2;
        reset = 1'b0;
        #1;
        check_output("async level", {29'd0, level}, 32'd0);
        check_output("async irq", {31'd0, irq}, 32'd0);
        check_output("async rd_data", bus.rd_data, 32'd0);
        check_output("async rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        bus.rd_en = 1'b0;
        btn_n     = 3'b111;
        tick(2);
        check_output("in reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        reset = 1'b1;
        tick(1);
        check_output("post reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        read_check("post reset count", 12'hFF2, 32'd0);
        read_check("post reset events", 12'hFF1, 32'd0);
        tick(D + 4);
        check_output("post reset level", {29'd0, level}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_event_port.md
Name: input_event_port

Overview:
- Memory-mapped button input port: the CPU-facing reader side of the player-control path (left, right, fire).
- Synchronises and debounces the raw active-low push buttons.
- Captures press events as sticky flags plus a saturating fire-press count. The processor polls these over a dmem-style read interface with read-to-clear semantics, so short taps between slow CPU polls are never lost.
- Sits between the board pins and the data-memory read mux; also exposes live debounced levels for the RAM-mapped movement inputs.

Parameters:
- DEBOUNCE_CYCLES, 5000000: consecutive clk cycles a synchronised input must differ from its debounced state before the state flips (legal range 2..2^CNT_W-1).
- CNT_W, 23: debounce counter width.
- BASE_ADDR, 12'hFF0: word address of register 0. Must be 4-word aligned.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- btn_left_n  input  1  raw left button, active-low, asynchronous to clk.
- btn_right_n  input  1  raw right button, active-low, asynchronous.
- btn_fire_n  input  1  raw fire button, active-low, asynchronous.
- rd_en  input  1  read strobe, one cycle per access.
- addr  input  12  word address.
- rd_data  output  32  registered read data.
- rd_valid  output  1  high exactly one cycle after an accepted rd_en.
- level  output  3  debounced pressed levels {fire, right, left}, active-high.
- irq  output  1  OR of all sticky event flags.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0.
  - Synchroniser flops reset to 1 (released).
  - Debounce counters, sticky flags and fire_count clear to 0.
  - Reset asserted mid-debounce or mid-read discards the in-progress count or read; no rd_valid is produced for a read cut off by reset.
- Input path, per button: the raw input is inverted and passed through a 2-FF synchroniser.
- Debounce, per button:
  - If sync == debounced, the counter clears.
  - Otherwise the counter increments.
  - When sync != debounced and counter == DEBOUNCE_CYCLES-1, debounced flips on that edge and the counter clears.
  - A single agreeing sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES never change level.
  - Latency from a raw edge to level change is exactly 2+DEBOUNCE_CYCLES clk edges.
- Events:
  - A 0->1 transition of debounced[i] sets sticky[i] in the same cycle level[i] rises.
  - A fire 0->1 transition also increments fire_count (8 bits, saturates at 255, never wraps).
  - Release edges generate no event.
- Register map: a read hits when addr[11:2]==BASE_ADDR[11:2]; offset = addr[1:0].
  - 0 STATUS: [2:0]=level, [10:8]=sticky. Side-effect free.
  - 1 EVENTS: [2:0]=sticky, read-to-clear.
  - 2 FIRE_COUNT: [7:0]=fire_count, read-to-clear.
  - 3, or any non-hit address: returns 0. rd_valid is still asserted, with no side effects.
  - All unused bits read 0.
- Read timing:
  - rd_data and rd_valid register on the edge following rd_en, giving 1-cycle latency.
  - rd_data holds its value until the next accepted read.
  - rd_valid is a single-cycle pulse.
  - Back-to-back rd_en on consecutive cycles is allowed; each access is served in order, one per cycle.
- Simultaneous events:
  - Sticky set and EVENTS read-clear in the same cycle: the read returns the pre-edge value and the bit ends at 1 (set wins).
  - fire_count increment and FIRE_COUNT read-clear in the same cycle: the read returns the old count and the count ends at 1.
  - Increment while at 255: stays at 255.
- irq is combinational from sticky and drops the cycle after a clearing read unless a new event arrives.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR=12'hFF0):
- Reset + idle: hold reset=0 for 3 cycles, release with all buttons high -> level=0, irq=0, rd_data=0, rd_valid=0; STATUS read returns 32'h0.
- Clean press: btn_fire_n 1->0 and held -> level[2] rises exactly 6 edges later, with irq=1 the same edge. EVENTS read at addr FF1 -> rd_valid next cycle, rd_data=32'h4. Second EVENTS read -> 32'h0. STATUS read -> 32'h4.
- Glitch reject: btn_left_n low for 3 cycles then high -> level[0] stays 0, sticky stays 0, irq stays 0. Then low for 10 cycles -> level[0]=1, sticky[0]=1.
- Count and saturation: 300 debounced fire presses -> FIRE_COUNT=32'd255. Read-clear -> next FIRE_COUNT read = 32'd0.
- Race: issue an EVENTS read in the exact cycle level[1] rises -> read returns 32'h0, sticky[1] remains 1, irq remains 1, next EVENTS read returns 32'h2. Same race on FIRE_COUNT with count 5 -> read 5, then 1.
- Unmapped + async reset: read addr FF3 and 000 -> rd_valid=1, rd_data=0, no state change. Assert reset mid-debounce (counter=2) -> all state and outputs 0 immediately, with no rd_valid afterward.
